// File: rtl/valid_delay_line_pkg.sv
// Shared helpers for the pipeline primitives.
// occ_width sizes any counter that must hold the values 0..depth inclusive.
package valid_delay_line_pkg;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/valid_delay_line_if.sv
// Handshake bundle between a producer/consumer pair and valid_delay_line.
// The master side drives the inputs; the slave side is the delay line itself.
interface valid_delay_line_if
    import valid_delay_line_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = occ_width(DEPTH);

    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic [OCC_W-1:0] occupancy;
    logic             empty;
    logic             full;

    modport master (
        output en, flush, in_valid, in,
        input  out_valid, out, occupancy, empty, full
    );

    modport slave (
        input  en, flush, in_valid, in,
        output out_valid, out, occupancy, empty, full
    );
endinterface

// File: rtl/valid_delay_line_delay_stage.sv
// One pipeline stage: a valid bit and a data word that advance together on en.
// Flush clears only the valid bit; the data word keeps following en.
module delay_stage #(
    parameter int WIDTH = 32,
    parameter int SAFE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    output logic             q_valid,
    output logic [WIDTH-1:0] q
);
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= (SAFE != 0) ? {WIDTH{1'b0}} : {WIDTH{1'bx}};
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (en) begin
                valid_reg <= d_valid;
            end
            if (en) begin
                data_reg <= d;
            end
        end
    end

    assign q_valid = valid_reg;
    assign q       = data_reg;
endmodule

// File: rtl/valid_delay_line.sv
// Stallable fixed-latency delay line: DEPTH stages of {valid, data} with flush
// and a running count of valid stages; outputs come straight from registers.
module valid_delay_line
    import valid_delay_line_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SAFE  = 0
) (
    input logic               clk,
    input logic               reset,
    valid_delay_line_if.slave bus
);
    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0] occupancy_reg;
    logic [OCC_W-1:0] occupancy_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             d_valid;
            logic [WIDTH-1:0] d;
            if (gi == 0) begin : g_head
                assign d_valid = bus.in_valid;
                assign d       = bus.in;
            end else begin : g_body
                assign d_valid = stage_valid[gi-1];
                assign d       = stage_data[gi-1];
            end
            delay_stage #(
                .WIDTH (WIDTH),
                .SAFE  (SAFE)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (bus.en),
                .flush   (bus.flush),
                .d_valid (d_valid),
                .d       (d),
                .q_valid (stage_valid[gi]),
                .q       (stage_data[gi])
            );
        end
    endgenerate

    // Entry and exit on the same shift edge cancel; the count cannot leave 0..DEPTH.
    always_comb begin
        occupancy_next = occupancy_reg;
        if (bus.flush) begin
            occupancy_next = '0;
        end else if (bus.en) begin
            occupancy_next = occupancy_reg + OCC_W'(bus.in_valid)
                                           - OCC_W'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (occupancy_reg == OCC_W'($countones(stage_valid)));
        end
    end

    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out       = stage_data[DEPTH-1];
    assign bus.occupancy = occupancy_reg;
    assign bus.empty     = (occupancy_reg == '0);
    assign bus.full      = (occupancy_reg == OCC_W'(DEPTH));
endmodule
